// File: rtl/acqbuf_pkg.sv
// acqbuf_pkg: shared types and reset constants
// for the acquisition-buffer writer blocks.
package acqbuf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        CAPTURE,
        DONE
    } acq_state_t;

    localparam int DLY_RST  = 0;
    localparam int DEC_RST  = 0;
    localparam int ADDR_RST = 0;
    localparam int DLY_LAST = 1;

endpackage

// File: rtl/acqbuf_decim.sv
// acqbuf_decim: keep-one-of-N decimation counter.
// keep marks the valid beats that should be written.
module acqbuf_decim
    import acqbuf_pkg::*;
#(
    parameter int DECWIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                valid,
    input  logic [DECWIDTH-1:0] decimator,
    output logic                keep
);

    logic [DECWIDTH-1:0] cnt;

    assign keep = valid && (cnt == '0);

    // Zero on start so the first eligible beat is kept,
    // then reload to decimator after every kept beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= DECWIDTH'(DEC_RST);
        end else if (load) begin
            cnt <= DECWIDTH'(DEC_RST);
        end else if (valid) begin
            if (cnt == '0)
                cnt <= decimator;
            else
                cnt <= cnt - DECWIDTH'(1);
        end
    end

endmodule

// File: rtl/acqbuf_capture.sv
// acqbuf_capture: triggered record writer from one of two
// ADC streams into a BRAM write port, with delay and decimation.
module acqbuf_capture
    import acqbuf_pkg::*;
#(
    parameter int DWIDTH   = 64,
    parameter int AWIDTH   = 12,
    parameter int DLYWIDTH = 16,
    parameter int DECWIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                acqbufreset,
    input  logic                trig,
    input  logic [DLYWIDTH-1:0] delayaftertrig,
    input  logic [DECWIDTH-1:0] decimator,
    input  logic                acqchansel,
    input  logic [DWIDTH-1:0]   adc0,
    input  logic [DWIDTH-1:0]   adc1,
    input  logic                adcvalid,
    output logic                bram_we,
    output logic [AWIDTH-1:0]   bram_waddr,
    output logic [DWIDTH-1:0]   bram_wdata,
    output logic                busy,
    output logic                done,
    output logic [AWIDTH:0]     addr_mon
);

    acq_state_t state;
    acq_state_t state_d;

    logic                clr;
    logic                start;
    logic                cap_valid;
    logic                keep;
    logic                last;
    logic [DLYWIDTH-1:0] dly_cnt;
    logic [DECWIDTH-1:0] dec_q;
    logic                sel_q;

    assign clr       = reset | acqbufreset;
    assign start     = (state == IDLE) && trig;
    assign cap_valid = (state == CAPTURE) && adcvalid;
    assign last      = keep && (&addr_mon[AWIDTH-1:0]);

    acqbuf_decim #(
        .DECWIDTH (DECWIDTH)
    ) u_decim (
        .clk       (clk),
        .reset     (clr),
        .load      (start),
        .valid     (cap_valid),
        .decimator (dec_q),
        .keep      (keep)
    );

    // Next-state logic; any reset source forces IDLE.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (trig)
                    state_d = (delayaftertrig == '0) ? CAPTURE : DELAY;
            end
            DELAY: begin
                if (dly_cnt == DLYWIDTH'(DLY_LAST))
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                if (last)
                    state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (clr)
            state_d = IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_d;
    end

    // Settings frozen at trigger plus the clock-based delay counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            dly_cnt <= DLYWIDTH'(DLY_RST);
            dec_q   <= DECWIDTH'(DEC_RST);
            sel_q   <= 1'b0;
        end else if (start) begin
            dly_cnt <= delayaftertrig;
            dec_q   <= decimator;
            sel_q   <= acqchansel;
        end else if (state == DELAY) begin
            dly_cnt <= dly_cnt - DLYWIDTH'(1);
        end
    end

    // Registered BRAM port and status; addr_mon doubles as write pointer.
    always_ff @(posedge clk) begin
        if (clr) begin
            bram_we    <= 1'b0;
            bram_waddr <= AWIDTH'(ADDR_RST);
            bram_wdata <= '0;
            addr_mon   <= (AWIDTH+1)'(ADDR_RST);
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            bram_we <= keep;
            if (keep) begin
                bram_wdata <= sel_q ? adc1 : adc0;
                bram_waddr <= addr_mon[AWIDTH-1:0];
                addr_mon   <= addr_mon + (AWIDTH+1)'(1);
            end
            busy <= (state_d == DELAY) || (state_d == CAPTURE);
            done <= (state == DONE);
        end
    end

endmodule

// File: doc/acqbuf_capture.md
# acqbuf_capture

Triggered acquisition-buffer writer in the DSP clock domain, directly downstream of the board-level ADC AXI-stream adapters. On each armed trigger it selects one of two ADC sample streams, waits a programmable delay, decimates, and writes a fixed-length record into a simple dual-port BRAM write port. Completion status and the live write address are reported back to the DSP register block.

## Interface
- DWIDTH, 64: ADC stream word width (one AXIS beat).
- AWIDTH, 12: buffer address width; record length is 2**AWIDTH words.
- DLYWIDTH, 16: width of delay-after-trigger setting.
- DECWIDTH, 8: width of decimation setting.

Ports:
- clk  in  1  DSP clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; returns the block to its reset state.
- acqbufreset  in  1  synchronous re-arm, active-high level; same effect as reset.
- trig  in  1  single-cycle start strobe (stb_start).
- delayaftertrig  in  DLYWIDTH  clocks from trigger to first capture.
- decimator  in  DECWIDTH  keep one of every decimator+1 valid beats.
- acqchansel  in  1  0 selects adc0, 1 selects adc1.
- adc0, adc1  in  DWIDTH each  ADC beats.
- adcvalid  in  1  beat qualifier for both ADC inputs.
- bram_we  out  1  write enable.
- bram_waddr  out  AWIDTH  write address.
- bram_wdata  out  DWIDTH  write data.
- busy  out  1  high in DELAY or CAPTURE.
- done  out  1  record complete; held until re-arm.
- addr_mon  out  AWIDTH+1  number of words written in this record.

## Operation
- States: IDLE, DELAY, CAPTURE, DONE.
- IDLE: trig=1 latches acqchansel, decimator, and delayaftertrig. The next state is CAPTURE if delay==0, otherwise DELAY. The delay counter is loaded with delayaftertrig.
- DELAY: counts clocks, not valid beats. Moves to CAPTURE when the counter reaches 1, so capture starts exactly delay cycles after the trigger edge.
- CAPTURE:
  - Writes only on cycles with adcvalid=1.
  - A decimation counter starts at 0. A write occurs when the counter is 0; it then reloads to decimator and decrements on each valid beat.
  - Each write increments the address and addr_mon.
  - After writing address 2**AWIDTH-1, the state moves to DONE. The address does not wrap into a second record.
- DONE: done=1, busy=0. trig is ignored. Only reset or acqbufreset returns to IDLE.
- trig is ignored in DELAY, CAPTURE and DONE.
- Settings and channel select are frozen at trigger. Register changes mid-record have no effect until the next record.
- reset/acqbufreset take priority over trig in the same cycle; that trig is dropped. Either one mid-record aborts immediately: bram_we=0 from the next cycle, and partially written data is left in the BRAM.
- Reset values: state IDLE, bram_we=0, bram_waddr=0, bram_wdata=0, busy=0, done=0, addr_mon=0, all counters 0.

## Timing
- All outputs are registered.
- Write latency: a valid beat sampled at edge N appears as bram_we/bram_wdata/bram_waddr after edge N, for one cycle per write.
- trig at edge T with delay D: busy rises after T. The first beat eligible for capture is the one present at edge T+1+D.
- done rises on the cycle after the final bram_we pulse. addr_mon reads 2**AWIDTH at that point and holds.
- Throughput: one write per clock with decimator=0 and continuous adcvalid.
- Minimum re-arm: acqbufreset for 1 cycle, then trig is accepted on the following cycle.

## Structure
- The shared package acqbuf_pkg holds:
  - the state enum typedef (IDLE, DELAY, CAPTURE, DONE);
  - localparams for the reset values of the counters.
- One natural sub-module, acqbuf_decim: the decimation counter with a load/valid/keep interface. It is reusable by the DAC-monitor buffer.
- No clock-domain crossing inside the block. Register inputs arrive already in the clk domain.

## Test plan
- Basic capture: AWIDTH=4, D=0, dec=0, continuous valid, adc0 = incrementing count starting at 100, trig. Expect 16 writes at addresses 0..15 with data 100..115, then done=1 and addr_mon=16.
- Delay and decimation: D=5, dec=2, adc1 selected, counter data. Expect the first write to be the beat at T+6, then every third beat. Expect exactly 16 writes, and acqchansel toggled mid-record to have no effect.
- Gapped valid: adcvalid toggling 1,0,1,0 with dec=1. Only valid beats are counted; expect writes on every second valid beat, i.e. every fourth clock.
- Ignored triggers: trig pulses during DELAY, CAPTURE and DONE. Expect no restart and no extra writes, and done to stay at 1.
- Abort and priority:
  - acqbufreset at write 7 → bram_we low the next cycle, busy=0, addr_mon=0.
  - trig in the same cycle as acqbufreset → stays IDLE.
  - trig one cycle later → a fresh record starting at address 0.
- Reset value check: assert reset mid-DELAY. All outputs go to 0 and the state to IDLE on the next edge.
